// File: rtl/button_debounce.sv
// button_debounce
// Conditions one active-low push-button into clean single-cycle events:
// two-flop synchroniser, stability-timer debounce, press/release strobes,
// and an auto-repeat pulse train while the button stays held. `step` is the
// increment strobe for the downstream LED counter (press OR repeat).
module button_debounce #(
    parameter int unsigned STABLE_CYCLES = 270000,   // 10 ms at 27 MHz
    parameter int unsigned HOLD_CYCLES   = 13500000, // 0.5 s, 0 disables repeat
    parameter int unsigned REPEAT_CYCLES = 2700000   // 0.1 s
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step
);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_REPEAT   = 2'd2
    } state_t;

    // Terminal counts; HOLD_LAST is meaningless (and unused) when HOLD_CYCLES is 0.
    localparam logic [23:0] STABLE_LAST = 24'(STABLE_CYCLES - 1);
    localparam logic [23:0] HOLD_LAST   = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] REPEAT_LAST = 24'(REPEAT_CYCLES - 1);
    localparam logic [23:0] CNT_MAX     = 24'hFF_FFFF;
    localparam logic        REPEAT_EN   = (HOLD_CYCLES != 0);

    logic [1:0]  sync_reg;
    logic        btn_s;
    state_t      state_reg;
    logic [23:0] cnt_reg;
    logic [23:0] hcnt_reg;

    logic        level_diff;
    logic        accept;
    logic        hold_expire;
    logic        rep_expire;

    // Two-flop synchroniser; resets to "released" so reset never fakes a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], btn_n};
        end
    end

    assign btn_s = ~sync_reg[1];

    // Decode debounce acceptance and timer expiries from the current state.
    always_comb begin
        level_diff  = (btn_s != pressed);
        accept      = level_diff && (cnt_reg == STABLE_LAST);
        hold_expire = REPEAT_EN && (state_reg == ST_PRESSED) && (hcnt_reg == HOLD_LAST);
        rep_expire  = (state_reg == ST_REPEAT) && (hcnt_reg == REPEAT_LAST);
    end

    // Debounce / hold-repeat FSM with registered level and strobe outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_RELEASED;
            cnt_reg       <= 24'd0;
            hcnt_reg      <= 24'd0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            step          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            step          <= 1'b0;

            // Run length of the disagreeing level; saturates rather than wraps.
            if (level_diff) begin
                if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + 24'd1;
                end
            end else begin
                cnt_reg <= 24'd0;
            end

            case (state_reg)
                ST_RELEASED: begin
                    hcnt_reg <= 24'd0;
                    if (accept) begin
                        state_reg   <= ST_PRESSED;
                        pressed     <= 1'b1;
                        press_pulse <= 1'b1;
                        step        <= 1'b1;
                        cnt_reg     <= 24'd0;
                    end
                end
                ST_PRESSED, ST_REPEAT: begin
                    // Release takes priority over a coincident repeat expiry.
                    if (accept) begin
                        state_reg     <= ST_RELEASED;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                        cnt_reg       <= 24'd0;
                        hcnt_reg      <= 24'd0;
                    end else if (hold_expire || rep_expire) begin
                        state_reg    <= ST_REPEAT;
                        repeat_pulse <= 1'b1;
                        step         <= 1'b1;
                        hcnt_reg     <= 24'd0;
                    end else begin
                        // Keeps running through short glitches so they cannot
                        // postpone the repeat schedule.
                        hcnt_reg <= hcnt_reg + 24'd1;
                    end
                end
                default: begin
                    state_reg <= ST_RELEASED;
                    pressed   <= 1'b0;
                    cnt_reg   <= 24'd0;
                    hcnt_reg  <= 24'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
// Table of per-scenario stimulus and expected event cycles. Cycle k is the
// value seen just before clock edge k; btn_n for cycle k is driven before
// edge k. Expected output vectors are queued as stimulus is driven and
// popped for comparison one cycle later.
module tb_button_debounce;

    localparam int STABLE = 4;
    localparam int HOLD   = 20;
    localparam int REP    = 8;
    localparam int BIG    = 100000;

    logic clk = 1'b0;
    logic rst;
    logic btn_n;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic step;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .STABLE_CYCLES(STABLE),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .step         (step)
    );

    typedef struct packed {
        logic pressed;
        logic press;
        logic rel;
        logic rep;
        logic step;
    } outv_t;

    typedef struct {
        string name;
        int    n;
        int    low_start;  // btn_n low in [low_start, low_end)
        int    low_end;
        int    gl_start;   // high glitch overriding the low window
        int    gl_len;
        int    rst_start;  // rst high in [rst_start, rst_end)
        int    rst_end;
        int    press0;
        int    press1;
        int    rep0;
        int    rep1;
        int    rep2;
        int    rel0;
        int    p0_from;    // pressed high in [p0_from, p0_to) and [p1_from, p1_to)
        int    p0_to;
        int    p1_from;
        int    p1_to;
    } vec_t;

    vec_t tbl [8];

    function automatic logic btn_at(input vec_t v, input int c);
        logic low;
        low = (c >= v.low_start) && (c < v.low_end) &&
              !((c >= v.gl_start) && (c < v.gl_start + v.gl_len));
        return !low;
    endfunction

    function automatic logic rst_at(input vec_t v, input int c);
        return (c >= v.rst_start) && (c < v.rst_end);
    endfunction

    function automatic outv_t expect_at(input vec_t v, input int c);
        outv_t e;
        e.press   = (c == v.press0) || (c == v.press1);
        e.rep     = (c == v.rep0) || (c == v.rep1) || (c == v.rep2);
        e.rel     = (c == v.rel0);
        e.step    = e.press | e.rep;
        e.pressed = ((c >= v.p0_from) && (c < v.p0_to)) ||
                    ((c >= v.p1_from) && (c < v.p1_to));
        return e;
    endfunction

    function automatic outv_t dut_out();
        outv_t a;
        a = {pressed, press_pulse, release_pulse, repeat_pulse, step};
        return a;
    endfunction

    task automatic check(input string name, input int c, input outv_t act, input outv_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: {pressed,press,rel,rep,step} got %b required %b",
                     name, c, act, req);
        end
    endtask

    task automatic check_onehot(input string name, input int c);
        int npulse;
        npulse = int'(press_pulse) + int'(release_pulse) + int'(repeat_pulse);
        n_cmp++;
        if (npulse > 1) begin
            n_bad++;
            $display("FAIL %s_onehot cycle %0d: got %0d pulses required at most 1", name, c, npulse);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        btn_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        outv_t q[$];
        outv_t req;
        q.push_back(expect_at(v, 0));
        for (int c = 0; c < v.n; c++) begin
            req = q.pop_front();
            check(v.name, c, dut_out(), req);
            check_onehot(v.name, c);
            btn_n = btn_at(v, c);
            rst   = rst_at(v, c);
            q.push_back(expect_at(v, c + 1));
            $display("%s cycle %0d: btn_n=%b rst=%b out=%b", v.name, c, btn_n, rst, dut_out());
            if (rst_at(v, c) && !rst_at(v, c - 1) && (c > 0)) begin
                // Asynchronous reset must clear everything without a clock edge.
                #1;
                check({v.name, "_async_rst"}, c, dut_out(), outv_t'(5'b00000));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{"reset_hold",     60, -1, -1,  -1, 0,  5,  8, -1, -1, -1, -1, -1, -1, -1,  -1, -1,  -1};
        tbl[1] = '{"clean_press",    20,  0, BIG, -1, 0, -1, -1,  6, -1, -1, -1, -1, -1,  6, BIG, -1,  -1};
        tbl[2] = '{"bounce",         24,  0, BIG,  3, 2, -1, -1, 11, -1, -1, -1, -1, -1, 11, BIG, -1,  -1};
        tbl[3] = '{"auto_repeat",    60,  0, 44,  -1, 0, -1, -1,  6, -1, 26, 34, 42, 50,  6,  50, -1,  -1};
        tbl[4] = '{"glitch_hold",    30,  0, BIG, 12, 2, -1, -1,  6, -1, 26, -1, -1, -1,  6, BIG, -1,  -1};
        tbl[5] = '{"reset_mid_hold", 50,  0, BIG, -1, 0, 30, 35,  6, 41, 26, -1, -1, -1,  6,  31, 41, BIG};
        tbl[6] = '{"short_run",      20,  0,  3,  -1, 0, -1, -1, -1, -1, -1, -1, -1, -1, -1,  -1, -1,  -1};
        tbl[7] = '{"exact_run",      20,  0,  4,  -1, 0, -1, -1,  6, -1, -1, -1, -1, 10,  6,  10, -1,  -1};

        rst   = 1'b1;
        btn_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", 0, dut_out(), outv_t'(5'b00000));
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("after_reset_idle", 0, dut_out(), outv_t'(5'b00000));

        for (int t = 0; t < 8; t++) begin
            do_reset();
            run_vec(tbl[t]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
